// File: rtl/mac_lookup_scheduler.sv
// Round-robin front end: N per-port header FIFOs share one MAC-learning lookup engine.
// Latency: valid seen in IDLE -> pop + lu_en next cycle; engine done -> rsp strobe next cycle.
// Backpressure: stalls in IDLE while the engine is busy; one lookup outstanding; flood result on timeout.
module mac_lookup_scheduler #(
  parameter int P_NUM_PORTS  = 4,
  parameter int P_MAC_WIDTH  = 48,
  parameter int P_PORT_WIDTH = 3,
  parameter int P_TIMEOUT    = 64,
  parameter int P_FLOOD_CODE = 4
) (
  input  logic                                                    clk,
  input  logic                                                    reset,
  input  logic [P_NUM_PORTS-1:0]                                  req_valid_i,
  input  logic [P_NUM_PORTS*(2*P_MAC_WIDTH+P_PORT_WIDTH)-1:0]     req_data_i,
  output logic [P_NUM_PORTS-1:0]                                  req_pop_o,
  input  logic                                                    lu_busy_i,
  output logic                                                    lu_en_o,
  output logic [P_MAC_WIDTH-1:0]                                  lu_src_mac_o,
  output logic [P_MAC_WIDTH-1:0]                                  lu_dst_mac_o,
  output logic [P_PORT_WIDTH-1:0]                                 lu_src_port_o,
  input  logic                                                    lu_done_i,
  input  logic [P_PORT_WIDTH-1:0]                                 lu_dst_port_i,
  output logic [P_NUM_PORTS-1:0]                                  rsp_done_o,
  output logic [P_PORT_WIDTH-1:0]                                 rsp_dst_port_o,
  output logic [15:0]                                             timeout_cnt_o
);

  localparam int TAG_W = (P_NUM_PORTS > 1) ? $clog2(P_NUM_PORTS) : 1;
  localparam int HDR_W = 2*P_MAC_WIDTH + P_PORT_WIDTH;
  localparam int TMR_W = (P_TIMEOUT > 1) ? $clog2(P_TIMEOUT) : 1;
  localparam logic [TAG_W-1:0]        LAST_RST = TAG_W'(P_NUM_PORTS-1);
  localparam logic [TMR_W-1:0]        TMR_LAST = TMR_W'(P_TIMEOUT-1);
  localparam logic [P_PORT_WIDTH-1:0] FLOOD    = P_PORT_WIDTH'(P_FLOOD_CODE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [HDR_W-1:0]        hdr [P_NUM_PORTS];
  logic [TAG_W-1:0]        last_grant;
  logic [TAG_W-1:0]        tag;
  logic [TAG_W-1:0]        grant;
  logic [TMR_W-1:0]        timer;
  logic                    take;
  logic                    done_hit;
  logic                    timeout_hit;
  logic [P_NUM_PORTS-1:0]  pop_nxt;
  logic                    en_nxt;
  logic [P_NUM_PORTS-1:0]  rsp_nxt;
  logic [P_PORT_WIDTH-1:0] rsp_dst_nxt;

  // Header layout per port slice, MSB first: {src_mac, dst_mac, src_port}.
  for (genvar p = 0; p < P_NUM_PORTS; p++) begin : g_slice
    assign hdr[p] = req_data_i[p*HDR_W +: HDR_W];
  end

  // Nearest valid port after the last grant, wrapping. Scanned far-to-near so the
  // nearest hit is the final assignment.
  function automatic logic [TAG_W-1:0] rr_pick(input logic [P_NUM_PORTS-1:0] v,
                                               input logic [TAG_W-1:0]       last);
    logic [TAG_W-1:0] pick;
    logic [TAG_W-1:0] idx;
    pick = last;
    for (int i = P_NUM_PORTS; i >= 1; i--) begin
      idx = TAG_W'((int'(last) + i) % P_NUM_PORTS);
      if (v[idx]) pick = idx;
    end
    return pick;
  endfunction

  assign grant       = rr_pick(req_valid_i, last_grant);
  assign take        = (state == S_IDLE) && (|req_valid_i) && !lu_busy_i;
  assign done_hit    = (state == S_WAIT) && lu_done_i;
  assign timeout_hit = (state == S_WAIT) && !lu_done_i && (timer == TMR_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: one issue cycle, then wait for done or timeout; done wins on a tie.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (take) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (done_hit || timeout_hit) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered strobes; the grant decided in IDLE pops and
  // starts the engine in the ISSUE cycle that follows.
  always_comb begin
    pop_nxt        = '0;
    rsp_nxt        = '0;
    rsp_dst_nxt    = '0;
    en_nxt         = take;
    pop_nxt[grant] = take;
    rsp_nxt[tag]   = done_hit || timeout_hit;
    if (done_hit)         rsp_dst_nxt = lu_dst_port_i;
    else if (timeout_hit) rsp_dst_nxt = FLOOD;
  end

  // Output registers, grant bookkeeping, wait timer and timeout counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      req_pop_o      <= '0;
      lu_en_o        <= 1'b0;
      rsp_done_o     <= '0;
      rsp_dst_port_o <= '0;
      lu_src_mac_o   <= '0;
      lu_dst_mac_o   <= '0;
      lu_src_port_o  <= '0;
      timeout_cnt_o  <= '0;
      last_grant     <= LAST_RST;
      tag            <= '0;
      timer          <= '0;
    end else begin
      req_pop_o      <= pop_nxt;
      lu_en_o        <= en_nxt;
      rsp_done_o     <= rsp_nxt;
      rsp_dst_port_o <= rsp_dst_nxt;
      if (take) begin
        lu_src_mac_o  <= hdr[grant][HDR_W-1 -: P_MAC_WIDTH];
        lu_dst_mac_o  <= hdr[grant][P_PORT_WIDTH +: P_MAC_WIDTH];
        lu_src_port_o <= hdr[grant][P_PORT_WIDTH-1:0];
        tag           <= grant;
        last_grant    <= grant;
      end
      if (state == S_ISSUE)     timer <= '0;
      else if (state == S_WAIT) timer <= timer + 1'b1;
      if (timeout_hit && (timeout_cnt_o != 16'hFFFF))
        timeout_cnt_o <= timeout_cnt_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_mac_lookup_scheduler.sv
// Bench for mac_lookup_scheduler: directed scenarios plus randomized traffic.
// Outputs are checked every cycle against an edge-count transaction model.
// Directed steps also pin exact literal values for grant order, latency and timeout.
module tb_mac_lookup_scheduler;

  localparam int N     = 4;
  localparam int MW    = 48;
  localparam int PW    = 3;
  localparam int TO    = 64;
  localparam int FLOOD = 4;
  localparam int DW    = 2*MW + PW;
  localparam int TW    = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [DW-1:0]   slot [N];
  logic [N-1:0]    req_pop;
  logic            lu_busy;
  logic            lu_en;
  logic [MW-1:0]   lu_src_mac;
  logic [MW-1:0]   lu_dst_mac;
  logic [PW-1:0]   lu_src_port;
  logic            lu_done;
  logic [PW-1:0]   lu_dst_port;
  logic [N-1:0]    rsp_done;
  logic [PW-1:0]   rsp_dst_port;
  logic [15:0]     timeout_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  for (genvar p = 0; p < N; p++) begin : g_pack
    assign req_data[p*DW +: DW] = slot[p];
  end

  always #5 clk = ~clk;

  mac_lookup_scheduler #(
    .P_NUM_PORTS(N), .P_MAC_WIDTH(MW), .P_PORT_WIDTH(PW),
    .P_TIMEOUT(TO), .P_FLOOD_CODE(FLOOD)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_pop_o(req_pop),
    .lu_busy_i(lu_busy), .lu_en_o(lu_en),
    .lu_src_mac_o(lu_src_mac), .lu_dst_mac_o(lu_dst_mac), .lu_src_port_o(lu_src_port),
    .lu_done_i(lu_done), .lu_dst_port_i(lu_dst_port),
    .rsp_done_o(rsp_done), .rsp_dst_port_o(rsp_dst_port),
    .timeout_cnt_o(timeout_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  // A grant is decided at edge g; relative to it (age = edges since g) the pop/en
  // pulse follows edge g, done is honoured at ages 2..TO+1, and with no done the
  // flood response follows age TO+1. The edge carrying the response is still busy.
  logic [N-1:0]  e_pop;
  logic          e_en;
  logic [N-1:0]  e_rsp;
  logic [PW-1:0] e_dst;
  logic [15:0]   e_cnt;
  logic [MW-1:0] e_smac;
  logic [MW-1:0] e_dmac;
  logic [PW-1:0] e_sport;
  logic [TW-1:0] m_last;
  logic [TW-1:0] m_tag;
  logic          m_owned;
  int            m_age;
  logic          m_ready = 1'b0;

  initial begin
    logic [TW-1:0] idx;
    logic [TW-1:0] pick;
    logic          found;
    logic [DW-1:0] sl;
    forever begin
      @(posedge clk);
      e_pop = '0; e_en = 1'b0; e_rsp = '0; e_dst = '0;
      if (!reset) begin
        m_owned = 1'b0; m_last = TW'(N-1); m_tag = '0; m_age = 0;
        e_cnt = '0; e_smac = '0; e_dmac = '0; e_sport = '0;
      end else if (!m_owned) begin
        if (req_valid != '0 && !lu_busy) begin
          found = 1'b0; pick = '0;
          for (int d = 1; d <= N; d++) begin
            idx = TW'((int'(m_last) + d) % N);
            if (!found && req_valid[idx]) begin found = 1'b1; pick = idx; end
          end
          sl = slot[pick];
          e_smac = sl[DW-1 -: MW]; e_dmac = sl[PW +: MW]; e_sport = sl[PW-1:0];
          e_pop[pick] = 1'b1; e_en = 1'b1;
          m_last = pick; m_tag = pick; m_owned = 1'b1; m_age = 0;
        end
      end else begin
        m_age++;
        if (m_age >= 2 && lu_done) begin
          e_rsp[m_tag] = 1'b1; e_dst = lu_dst_port; m_owned = 1'b0;
        end else if (m_age == TO + 1) begin
          e_rsp[m_tag] = 1'b1; e_dst = PW'(FLOOD); m_owned = 1'b0;
          if (e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
        end
      end
      m_ready = 1'b1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (m_ready) begin
        chk("req_pop",      64'(req_pop),      64'(e_pop));
        chk("lu_en",        64'(lu_en),        64'(e_en));
        chk("rsp_done",     64'(rsp_done),     64'(e_rsp));
        chk("rsp_dst_port", 64'(rsp_dst_port), 64'(e_dst));
        chk("timeout_cnt",  64'(timeout_cnt),  64'(e_cnt));
        chk("lu_src_mac",   64'(lu_src_mac),   64'(e_smac));
        chk("lu_dst_mac",   64'(lu_dst_mac),   64'(e_dmac));
        chk("lu_src_port",  64'(lu_src_port),  64'(e_sport));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic rand_data();
    for (int p = 0; p < N; p++) slot[p] = DW'({$urandom(), $urandom(), $urandom(), $urandom()});
  endtask

  task automatic wait_en(output int port, output int ticks);
    port = -1; ticks = 0;
    while (ticks < 40) begin
      @(negedge clk); ticks++;
      if (lu_en === 1'b1) begin
        for (int i = 0; i < N; i++) if (req_pop[i] === 1'b1) port = i;
        break;
      end
    end
    chk("en_seen", 64'(port >= 0), 64'(1));
  endtask

  // Done is sampled on the delay-th edge after the en pulse; returns with the
  // response visible.
  task automatic answer(input int delay, input logic [PW-1:0] dst);
    repeat (delay - 1) @(negedge clk);
    lu_done = 1'b1; lu_dst_port = dst;
    @(negedge clk);
    lu_done = 1'b0; lu_dst_port = '0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  // ---------------- directed scenarios, then random traffic ----------------
  initial begin
    int p, t, bad;
    reset = 1'b0; req_valid = '0; lu_busy = 1'b0; lu_done = 1'b0; lu_dst_port = '0;
    rand_data();
    repeat (3) @(negedge clk);
    chk("rst_pop", 64'(req_pop), 64'(0));
    chk("rst_en",  64'(lu_en),   64'(0));
    chk("rst_rsp", 64'(rsp_done), 64'(0));
    chk("rst_cnt", 64'(timeout_cnt), 64'(0));
    reset = 1'b1;

    // All ports valid, engine answers in 3: grants 0,1,2,3,0.
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_en(p, t);
      chk("rr_grant", 64'(p), 64'(k % 4));
      answer(3, PW'(k));
      chk("rr_rsp", 64'(rsp_done), 64'(4'b0001 << (k % 4)));
    end
    req_valid = '0;

    // Only port 2, done 5 cycles after en with dst 1.
    rand_data(); req_valid = 4'b0100;
    wait_en(p, t);
    chk("p2_latency", 64'(t), 64'(1));
    chk("p2_pop", 64'(req_pop), 64'(4'b0100));
    req_valid = '0;
    answer(5, 3'd1);
    chk("p2_rsp", 64'(rsp_done), 64'(4'b0100));
    chk("p2_dst", 64'(rsp_dst_port), 64'(1));

    // Port 1, engine silent -> flood after 64 wait cycles.
    rand_data(); req_valid = 4'b0010;
    wait_en(p, t);
    req_valid = '0;
    t = 0;
    while (t < 100 && rsp_done === '0) begin @(negedge clk); t++; end
    chk("to_cycles", 64'(t), 64'(TO + 1));
    chk("to_rsp", 64'(rsp_done), 64'(4'b0010));
    chk("to_dst", 64'(rsp_dst_port), 64'(4));
    chk("to_cnt", 64'(timeout_cnt), 64'(1));

    // Port 3, done arrives exactly in the timeout cycle.
    rand_data(); req_valid = 4'b1000;
    wait_en(p, t);
    req_valid = '0;
    answer(TO + 1, 3'd2);
    chk("tie_rsp", 64'(rsp_done), 64'(4'b1000));
    chk("tie_dst", 64'(rsp_dst_port), 64'(2));
    chk("tie_cnt", 64'(timeout_cnt), 64'(1));

    // Busy stall with ports 0 and 3 valid; port 0 first once busy drops.
    rand_data(); lu_busy = 1'b1; req_valid = 4'b1001; bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (lu_en !== 1'b0 || req_pop !== '0) bad++;
    end
    chk("busy_stall", 64'(bad), 64'(0));
    lu_busy = 1'b0;
    wait_en(p, t);
    chk("busy_grant", 64'(p), 64'(0));
    chk("busy_latency", 64'(t), 64'(1));
    req_valid = '0;
    answer(2, 3'd5);
    chk("busy_dst", 64'(rsp_dst_port), 64'(5));

    // Reset during WAIT, stray done afterwards, then grant restarts at port 0.
    rand_data(); req_valid = 4'b0100;
    wait_en(p, t);
    req_valid = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_en",   64'(lu_en), 64'(0));
    chk("mid_rst_mac",  64'(lu_src_mac), 64'(0));
    chk("mid_rst_cnt",  64'(timeout_cnt), 64'(0));
    reset = 1'b1; lu_done = 1'b1; lu_dst_port = 3'd3;
    @(negedge clk);
    lu_done = 1'b0; lu_dst_port = '0;
    chk("stray_done", 64'(rsp_done), 64'(0));
    req_valid = 4'b1111;
    wait_en(p, t);
    chk("post_rst_grant", 64'(p), 64'(0));
    req_valid = '0;
    answer(3, 3'd6);

    // Random traffic; a silent-engine window forces timeouts.
    for (int it = 0; it < 3000; it++) begin
      @(negedge clk);
      rand_data();
      req_valid   = N'($urandom_range(0, 15));
      lu_busy     = ($urandom_range(0, 7) == 0);
      lu_done     = (it >= 2000 && it < 2400) ? 1'b0 : ($urandom_range(0, 4) == 0);
      lu_dst_port = PW'($urandom_range(0, 7));
      reset       = ($urandom_range(0, 499) != 0);
    end
    @(negedge clk);
    reset = 1'b1; req_valid = '0; lu_busy = 1'b0; lu_done = 1'b0; lu_dst_port = '0;
    repeat (80) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
